// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths, FIFO depth and CDB source encoding
// Purpose: common constants for the CDB arbiter slice.
//   DAT_W_DEF / ROB_BIT_DEF : default result data / ROB tag widths
//   RES_FIFO_D              : default entries per producer result FIFO
//   cdb_src_e               : CDB source id (ALU = 0, LSB = 1)
package cdb_arbiter_pkg;

   localparam int DAT_W_DEF   = 32;
   localparam int ROB_BIT_DEF = 4;
   localparam int RES_FIFO_D  = 2;

   typedef enum logic {
      CDB_SRC_ALU = 1'b0,
      CDB_SRC_LSB = 1'b1
   } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer/CDB bundle between the core and the CDB arbiter
// Purpose: groups run control, both producer result ports and the CDB broadcast.
//   en, br_flag                  : run enable, mispredict flush
//   alu_en_i/q_i/v_i, alu_rdy_o  : ALU result push and FIFO ready
//   lsb_en_i/q_i/v_i, lsb_rdy_o  : LSB result push and FIFO ready
//   cdb_en_o/q_o/v_o/src_o       : CDB broadcast
// Modports: master = core/producer side, slave = arbiter side.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int DAT_W   = DAT_W_DEF,
   parameter int ROB_BIT = ROB_BIT_DEF
);
   logic               en;
   logic               br_flag;
   logic               alu_en_i;
   logic [ROB_BIT-1:0] alu_q_i;
   logic [DAT_W-1:0]   alu_v_i;
   logic               alu_rdy_o;
   logic               lsb_en_i;
   logic [ROB_BIT-1:0] lsb_q_i;
   logic [DAT_W-1:0]   lsb_v_i;
   logic               lsb_rdy_o;
   logic               cdb_en_o;
   logic [ROB_BIT-1:0] cdb_q_o;
   logic [DAT_W-1:0]   cdb_v_o;
   logic               cdb_src_o;

   modport master (
      output en, br_flag,
      output alu_en_i, alu_q_i, alu_v_i, input alu_rdy_o,
      output lsb_en_i, lsb_q_i, lsb_v_i, input lsb_rdy_o,
      input  cdb_en_o, cdb_q_o, cdb_v_o, cdb_src_o
   );

   modport slave (
      input  en, br_flag,
      input  alu_en_i, alu_q_i, alu_v_i, output alu_rdy_o,
      input  lsb_en_i, lsb_q_i, lsb_v_i, output lsb_rdy_o,
      output cdb_en_o, cdb_q_o, cdb_v_o, cdb_src_o
   );
endinterface

// File: rtl/cdb_arbiter_res_fifo.sv
// rtl/cdb_arbiter_res_fifo.sv - per-producer result FIFO holding {tag, value}
// Purpose: small circular FIFO; callers gate push/pop, flush empties it.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : empty the FIFO (stored data is left stale)
//   push, push_q/push_v : write one entry at tail
//   pop                 : drop the head entry
//   head_q, head_v      : current head entry (valid only when !empty)
//   count, full, empty  : occupancy
module res_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int DAT_W   = DAT_W_DEF,
   parameter int ROB_BIT = ROB_BIT_DEF,
   parameter int FIFO_D  = RES_FIFO_D,
   localparam int PW     = $clog2(FIFO_D),
   localparam int CW     = PW + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic [ROB_BIT-1:0] push_q,
   input  logic [DAT_W-1:0]   push_v,
   input  logic               pop,
   output logic [ROB_BIT-1:0] head_q,
   output logic [DAT_W-1:0]   head_v,
   output logic [CW-1:0]      count,
   output logic               full,
   output logic               empty
);
   logic [ROB_BIT-1:0] q_mem [FIFO_D];
   logic [DAT_W-1:0]   v_mem [FIFO_D];
   logic [PW-1:0]      head;
   logic [PW-1:0]      tail;

   // Pointers wrap naturally because FIFO_D is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_mem[tail] <= push_q;
         v_mem[tail] <= push_v;
      end
   end

   assign head_q = q_mem[head];
   assign head_v = v_mem[head];
   assign full   = (count == CW'(FIFO_D));
   assign empty  = (count == '0);
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving one ALU/LSB result per cycle onto the CDB
// Purpose: buffers each producer in a res_fifo and broadcasts one head per cycle,
// alternating under contention; br_flag empties both FIFOs, en=0 freezes everything.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cdb_arbiter_if.slave (run control, producer ports, CDB broadcast)
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int DAT_W   = DAT_W_DEF,
   parameter int ROB_BIT = ROB_BIT_DEF,
   parameter int FIFO_D  = RES_FIFO_D,
   localparam int CW     = $clog2(FIFO_D) + 1
) (
   input logic            clk,
   input logic            rst,
   cdb_arbiter_if.slave   bus
);
   logic               active;
   logic               alu_full, alu_empty, lsb_full, lsb_empty;
   logic [CW-1:0]      alu_cnt, lsb_cnt;
   logic [ROB_BIT-1:0] alu_hq, lsb_hq;
   logic [DAT_W-1:0]   alu_hv, lsb_hv;
   logic               alu_push, lsb_push, alu_pop, lsb_pop;
   logic               cdb_en;
   cdb_src_e           grant;
   cdb_src_e           last;

   assign active = bus.en & ~bus.br_flag;

   // Ready depends only on registered occupancy, so a pop in the same cycle
   // never lets a full FIFO take a new entry.
   assign bus.alu_rdy_o = active & ~alu_full;
   assign bus.lsb_rdy_o = active & ~lsb_full;
   assign alu_push      = bus.alu_rdy_o & bus.alu_en_i;
   assign lsb_push      = bus.lsb_rdy_o & bus.lsb_en_i;

   // Under contention the side that did not win last time goes next.
   assign grant  = (!alu_empty && (lsb_empty || last == CDB_SRC_LSB)) ? CDB_SRC_ALU : CDB_SRC_LSB;
   assign cdb_en = active & ~(alu_empty & lsb_empty);
   assign alu_pop = cdb_en & (grant == CDB_SRC_ALU);
   assign lsb_pop = cdb_en & (grant == CDB_SRC_LSB);

   assign bus.cdb_en_o  = cdb_en;
   assign bus.cdb_q_o   = !cdb_en ? '0 : (grant == CDB_SRC_LSB) ? lsb_hq : alu_hq;
   assign bus.cdb_v_o   = !cdb_en ? '0 : (grant == CDB_SRC_LSB) ? lsb_hv : alu_hv;
   assign bus.cdb_src_o = cdb_en & (grant == CDB_SRC_LSB);

   // Reset to LSB so the ALU wins the first tie; a flush keeps the history.
   always_ff @(posedge clk) begin
      if (rst)         last <= CDB_SRC_LSB;
      else if (cdb_en) last <= grant;
   end

   res_fifo #(.DAT_W(DAT_W), .ROB_BIT(ROB_BIT), .FIFO_D(FIFO_D)) u_alu_fifo (
      .clk(clk), .rst(rst), .flush(bus.br_flag),
      .push(alu_push), .push_q(bus.alu_q_i), .push_v(bus.alu_v_i), .pop(alu_pop),
      .head_q(alu_hq), .head_v(alu_hv), .count(alu_cnt), .full(alu_full), .empty(alu_empty)
   );

   res_fifo #(.DAT_W(DAT_W), .ROB_BIT(ROB_BIT), .FIFO_D(FIFO_D)) u_lsb_fifo (
      .clk(clk), .rst(rst), .flush(bus.br_flag),
      .push(lsb_push), .push_q(bus.lsb_q_i), .push_v(bus.lsb_v_i), .pop(lsb_pop),
      .head_q(lsb_hq), .head_v(lsb_hv), .count(lsb_cnt), .full(lsb_full), .empty(lsb_empty)
   );

   // Producer contract while the arbiter is running: push only when ready,
   // never with the reserved tag 0. Pushes during flush are simply discarded.
   a_alu_push: assert property (@(posedge clk) disable iff (rst)
      (bus.alu_en_i && active) |-> (bus.alu_rdy_o && bus.alu_q_i != '0));
   a_lsb_push: assert property (@(posedge clk) disable iff (rst)
      (bus.lsb_en_i && active) |-> (bus.lsb_rdy_o && bus.lsb_q_i != '0));
   a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
      (alu_cnt <= CW'(FIFO_D)) && (lsb_cnt <= CW'(FIFO_D)));
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter with directed and random traffic
module tb_cdb_arbiter;
   localparam int DW = 32;
   localparam int RB = 4;
   localparam int D  = 2;

   typedef struct packed {
      logic [RB-1:0] q;
      logic [DW-1:0] v;
      logic          src;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cdb_arbiter_if #(.DAT_W(DW), .ROB_BIT(RB)) bus ();
   cdb_arbiter #(.DAT_W(DW), .ROB_BIT(RB), .FIFO_D(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   int   n_chk  = 0;
   int   n_fail = 0;
   ent_t m_alu[$];
   ent_t m_lsb[$];
   ent_t exp_bc[$];
   bit   exp_en[$];
   bit   m_last = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the reference model works on whole entries in queues.
   task automatic cycle(input bit e, input bit b, input bit ao, input logic [RB-1:0] at,
                        input logic [DW-1:0] av, input bit lo, input logic [RB-1:0] lt,
                        input logic [DW-1:0] lv);
      bit   act, ar, lr, any, g;
      ent_t x;
      @(negedge clk);
      act = e && !b;
      ar  = act && (m_alu.size() < D);
      lr  = act && (m_lsb.size() < D);
      bus.en       = e;
      bus.br_flag  = b;
      bus.alu_q_i  = at;
      bus.alu_v_i  = av;
      bus.lsb_q_i  = lt;
      bus.lsb_v_i  = lv;
      bus.alu_en_i = ao && (ar || b);
      bus.lsb_en_i = lo && (lr || b);
      any = act && (m_alu.size() > 0 || m_lsb.size() > 0);
      exp_en.push_back(any);
      if (any) begin
         if (m_alu.size() > 0 && m_lsb.size() > 0) g = !m_last;
         else g = (m_lsb.size() > 0);
         x = g ? m_lsb.pop_front() : m_alu.pop_front();
         exp_bc.push_back(x);
         m_last = g;
      end
      if (b) begin
         m_alu.delete();
         m_lsb.delete();
      end else if (act) begin
         if (ao && ar) m_alu.push_back('{q: at, v: av, src: 1'b0});
         if (lo && lr) m_lsb.push_back('{q: lt, v: lv, src: 1'b1});
      end
      #1;
      chk("alu_rdy", {63'd0, bus.alu_rdy_o}, {63'd0, ar});
      chk("lsb_rdy", {63'd0, bus.lsb_rdy_o}, {63'd0, lr});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
   endtask

   task automatic both_rand(input int n);
      for (int i = 0; i < n; i++)
         cycle(1, 0, 1, 4'($urandom_range(1, 15)), $urandom, 1, 4'($urandom_range(1, 15)), $urandom);
   endtask

   // Monitor: every modelled cycle, compare the bus against the oldest expectation.
   initial begin
      bit   e;
      ent_t x;
      forever begin
         @(negedge clk);
         #2;
         if (exp_en.size() > 0) begin
            e = exp_en.pop_front();
            chk("cdb_en", {63'd0, bus.cdb_en_o}, {63'd0, e});
            if (bus.cdb_en_o) begin
               if (exp_bc.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL cdb_extra: got q=%0h v=%0h, required no broadcast", bus.cdb_q_o, bus.cdb_v_o);
               end else begin
                  x = exp_bc.pop_front();
                  chk("cdb_q", 64'(bus.cdb_q_o), 64'(x.q));
                  chk("cdb_v", 64'(bus.cdb_v_o), 64'(x.v));
                  chk("cdb_src", {63'd0, bus.cdb_src_o}, {63'd0, x.src});
               end
            end else begin
               chk("cdb_idle", {27'd0, bus.cdb_q_o, bus.cdb_v_o, bus.cdb_src_o}, 64'd0);
            end
         end
      end
   end

   initial begin
      bus.en = 1'b1; bus.br_flag = 1'b0;
      bus.alu_en_i = 1'b0; bus.alu_q_i = '0; bus.alu_v_i = '0;
      bus.lsb_en_i = 1'b0; bus.lsb_q_i = '0; bus.lsb_v_i = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_cdb_en", {63'd0, bus.cdb_en_o}, 64'd0);
      chk("rst_cdb_bus", {27'd0, bus.cdb_q_o, bus.cdb_v_o, bus.cdb_src_o}, 64'd0);
      chk("rst_alu_rdy", {63'd0, bus.alu_rdy_o}, 64'd1);
      chk("rst_lsb_rdy", {63'd0, bus.lsb_rdy_o}, 64'd1);
      bus.en = 1'b0;
      #1;
      chk("rst_rdy_en0", {62'd0, bus.alu_rdy_o, bus.lsb_rdy_o}, 64'd0);
      bus.en = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Single ALU push, then tie between producers.
      cycle(1, 0, 1, 4'd3, 32'h11, 0, 4'd0, 32'd0);
      idle(2);
      cycle(1, 0, 1, 4'd5, 32'hA, 1, 4'd6, 32'hB);
      idle(3);

      // Contention, then ALU-only pressure until its FIFO fills and drains.
      both_rand(20);
      for (int i = 0; i < 4; i++) cycle(1, 0, 1, 4'($urandom_range(1, 15)), $urandom, 0, 4'd0, 32'd0);
      idle(4);

      // Queue entries in both, then flush while both producers offer.
      both_rand(6);
      cycle(1, 1, 1, 4'd9, 32'hDEAD, 1, 4'd10, 32'hBEEF);
      idle(3);

      // Freeze with entries queued, then resume.
      both_rand(6);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'd1, 32'd0, 0, 4'd1, 32'd0);
      idle(6);

      // Random traffic with occasional stalls and flushes.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 2) != 0, 4'($urandom_range(1, 15)), $urandom,
               $urandom_range(0, 2) != 0, 4'($urandom_range(1, 15)), $urandom);
      end
      idle(8);

      @(negedge clk);
      #3;
      chk("drain_bc", 64'(exp_bc.size()), 64'd0);
      chk("drain_en", 64'(exp_en.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
